// File: rtl/rf_operand_fetch_pkg.sv
// Shared defaults for the operand-fetch slice: data/address widths and
// the number of operand lanes and snooped write-back ports.
package rf_operand_fetch_pkg;

    localparam int unsigned RF_DW_DEFAULT        = 64;
    localparam int unsigned RF_AW_DEFAULT        = 5;
    localparam int unsigned RF_NUM_READ_DEFAULT  = 2;
    localparam int unsigned RF_NUM_WRITE_DEFAULT = 2;

endpackage

// File: rtl/rf_byp_lane.sv
// One operand lane: captures address/enable on accept and tracks the
// latest matching write-back, both at accept and while the operand is held.
module rf_byp_lane
    import rf_operand_fetch_pkg::*;
#(
    parameter int unsigned DW        = RF_DW_DEFAULT,
    parameter int unsigned AW        = RF_AW_DEFAULT,
    parameter int unsigned NUM_WRITE = RF_NUM_WRITE_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    accept_i,
    input  logic                    hold_i,
    input  logic                    re_i,
    input  logic [AW-1:0]           raddr_i,
    input  logic [NUM_WRITE-1:0]    wb_we_i,
    input  logic [NUM_WRITE*AW-1:0] wb_waddr_i,
    input  logic [NUM_WRITE*DW-1:0] wb_wdata_i,
    input  logic [DW-1:0]           rf_rdata_i,
    output logic [DW-1:0]           rdata_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic          en_q,   en_d;
    logic          hit_q,  hit_d;
    logic [DW-1:0] byp_q,  byp_d;

    logic [AW-1:0] cmp_addr;
    logic          match;
    logic [DW-1:0] match_data;

    // Ascending scan so the highest-index matching port wins, as in the RF.
    always_comb begin
        cmp_addr   = accept_i ? raddr_i : addr_q;
        match      = 1'b0;
        match_data = '0;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wb_we_i[j] && (wb_waddr_i[j*AW +: AW] == cmp_addr)) begin
                match      = 1'b1;
                match_data = wb_wdata_i[j*DW +: DW];
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        hit_d  = hit_q;
        byp_d  = byp_q;
        if (accept_i) begin
            addr_d = raddr_i;
            en_d   = re_i;
            hit_d  = match;
            if (match) begin
                byp_d = match_data;
            end
        end else if (hold_i && en_q && match) begin
            hit_d = 1'b1;
            byp_d = match_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q  <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            hit_q <= hit_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        byp_q  <= byp_d;
    end

    assign rdata_o = !en_q ? '0 : (hit_q ? byp_q : rf_rdata_i);

endmodule

// File: rtl/rf_operand_fetch.sv
// Single-stage operand fetch: issues register-file reads on accept and
// presents operands one cycle later, bypassing in-flight write-backs.
module rf_operand_fetch
    import rf_operand_fetch_pkg::*;
#(
    parameter int unsigned DW        = RF_DW_DEFAULT,
    parameter int unsigned AW        = RF_AW_DEFAULT,
    parameter int unsigned NUM_READ  = RF_NUM_READ_DEFAULT,
    parameter int unsigned NUM_WRITE = RF_NUM_WRITE_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    I_VALID,
    output logic                    I_READY,
    input  logic [NUM_READ-1:0]     I_RE,
    input  logic [NUM_READ*AW-1:0]  I_RADDR,
    output logic [NUM_READ-1:0]     RF_RE,
    output logic [NUM_READ*AW-1:0]  RF_RADDR,
    input  logic [NUM_READ*DW-1:0]  RF_RDATA,
    input  logic [NUM_WRITE-1:0]    WB_WE,
    input  logic [NUM_WRITE*AW-1:0] WB_WADDR,
    input  logic [NUM_WRITE*DW-1:0] WB_WDATA,
    output logic                    O_VALID,
    input  logic                    O_READY,
    output logic [NUM_READ*DW-1:0]  O_RDATA
);

    logic o_valid_q, o_valid_d;
    logic accept;
    logic hold;

    // Reset gates accept so a request presented during reset never reaches the RF.
    assign I_READY  = !o_valid_q || O_READY;
    assign accept   = RST_N && I_VALID && I_READY;
    assign hold     = o_valid_q && !O_READY;
    assign RF_RE    = accept ? I_RE : '0;
    assign RF_RADDR = I_RADDR;
    assign O_VALID  = o_valid_q;

    always_comb begin
        o_valid_d = o_valid_q;
        if (accept) begin
            o_valid_d = 1'b1;
        end else if (O_READY) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_lane
        rf_byp_lane #(
            .DW        (DW),
            .AW        (AW),
            .NUM_WRITE (NUM_WRITE)
        ) u_lane (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .accept_i   (accept),
            .hold_i     (hold),
            .re_i       (I_RE[i]),
            .raddr_i    (I_RADDR[i*AW +: AW]),
            .wb_we_i    (WB_WE),
            .wb_waddr_i (WB_WADDR),
            .wb_wdata_i (WB_WDATA),
            .rf_rdata_i (RF_RDATA[i*DW +: DW]),
            .rdata_o    (O_RDATA[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: a register-file model feeds RF_RDATA and a
// scoreboard compares each consumed operand set with architectural state.
module tb_rf_operand_fetch;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             I_VALID;
    logic             I_READY;
    logic [NR-1:0]    I_RE;
    logic [NR*AW-1:0] I_RADDR;
    logic [NR-1:0]    RF_RE;
    logic [NR*AW-1:0] RF_RADDR;
    logic [NR*DW-1:0] RF_RDATA = '0;
    logic [NW-1:0]    WB_WE;
    logic [NW*AW-1:0] WB_WADDR;
    logic [NW*DW-1:0] WB_WDATA;
    logic             O_VALID;
    logic             O_READY;
    logic [NR*DW-1:0] O_RDATA;

    rf_operand_fetch #(
        .DW        (DW),
        .AW        (AW),
        .NUM_READ  (NR),
        .NUM_WRITE (NW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .I_VALID  (I_VALID),
        .I_READY  (I_READY),
        .I_RE     (I_RE),
        .I_RADDR  (I_RADDR),
        .RF_RE    (RF_RE),
        .RF_RADDR (RF_RADDR),
        .RF_RDATA (RF_RDATA),
        .WB_WE    (WB_WE),
        .WB_WADDR (WB_WADDR),
        .WB_WDATA (WB_WDATA),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .O_RDATA  (O_RDATA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int pops     = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-file model: pre-write read data, highest write port wins.
    logic [DW-1:0] regs [32];

    always @(posedge CLK) begin
        for (int i = 0; i < NR; i++) begin
            if (RF_RE[i]) RF_RDATA[i*DW +: DW] <= regs[RF_RADDR[i*AW +: AW]];
        end
        for (int j = 0; j < NW; j++) begin
            if (WB_WE[j]) regs[WB_WADDR[j*AW +: AW]] <= WB_WDATA[j*DW +: DW];
        end
    end

    typedef struct packed {
        logic [NR-1:0]    re;
        logic [NR*AW-1:0] addr;
    } req_t;

    req_t q[$];

    always @(negedge CLK) begin
        req_t          it;
        logic [127:0]  exp;
        if (!RST_N) begin
            q.delete();
        end else begin
            if (O_VALID && O_READY) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 128'(1), 128'(0));
                end else begin
                    it  = q.pop_front();
                    exp = '0;
                    for (int i = 0; i < NR; i++) begin
                        if (it.re[i]) exp[i*DW +: DW] = regs[it.addr[i*AW +: AW]];
                    end
                    check("sb_data", 128'(O_RDATA), exp);
                    pops++;
                end
            end
            if (I_VALID && I_READY) begin
                it.re   = I_RE;
                it.addr = I_RADDR;
                q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        I_VALID = 1'b0;
        I_RE    = '0;
        WB_WE   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pops0;
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        regs[3] = 64'h11;
        regs[4] = 64'h22;
        regs[7] = 64'h5;

        RST_N    = 1'b0;
        O_READY  = 1'b1;
        I_RADDR  = '0;
        WB_WADDR = '0;
        WB_WDATA = '0;
        idle();
        step();
        I_VALID = 1'b1;
        I_RE    = 2'b11;
        @(negedge CLK);
        check("rst_rf_re", 128'(RF_RE), 128'(0));
        step();
        @(negedge CLK);
        check("rst_o_valid", 128'(O_VALID), 128'(0));
        check("rst_i_ready", 128'(I_READY), 128'(1));

        // Basic read of r3/r4
        step();
        RST_N   = 1'b1;
        I_VALID = 1'b1;
        I_RE    = 2'b11;
        I_RADDR = {5'd4, 5'd3};
        @(negedge CLK);
        check("basic_rf_re", 128'(RF_RE), 128'(2'b11));
        check("basic_rf_raddr", 128'(RF_RADDR), 128'({5'd4, 5'd3}));
        step();
        idle();
        @(negedge CLK);
        check("basic_valid", 128'(O_VALID), 128'(1));
        check("basic_data", 128'(O_RDATA), {64'h22, 64'h11});

        // Same-cycle bypass, single writer
        step();
        I_VALID  = 1'b1;
        I_RE     = 2'b11;
        I_RADDR  = {5'd6, 5'd5};
        WB_WE    = 2'b01;
        WB_WADDR = {5'd0, 5'd5};
        WB_WDATA = {64'h0, 64'hAB};
        step();
        idle();
        @(negedge CLK);
        check("byp_single", 128'(O_RDATA[63:0]), 128'(64'hAB));

        // Two writers to the same register: port 1 wins
        step();
        I_VALID  = 1'b1;
        I_RE     = 2'b01;
        I_RADDR  = {5'd0, 5'd5};
        WB_WE    = 2'b11;
        WB_WADDR = {5'd5, 5'd5};
        WB_WDATA = {64'h2, 64'h1};
        @(negedge CLK);
        check("waw_rf_re", 128'(RF_RE), 128'(2'b01));
        step();
        idle();
        @(negedge CLK);
        check("byp_waw", 128'(O_RDATA), {64'h0, 64'h2});

        // Hold with refresh on r7, lane 1 masked
        step();
        I_VALID = 1'b1;
        I_RE    = 2'b01;
        I_RADDR = {5'd7, 5'd7};
        O_READY = 1'b0;
        @(negedge CLK);
        check("mask_rf_re", 128'(RF_RE), 128'(2'b01));
        step();
        idle();
        @(negedge CLK);
        check("hold1_data", 128'(O_RDATA), {64'h0, 64'h5});
        check("hold1_ready", 128'(I_READY), 128'(0));
        step();
        WB_WE    = 2'b01;
        WB_WADDR = {5'd0, 5'd7};
        WB_WDATA = {64'h0, 64'h9};
        @(negedge CLK);
        check("hold2_data", 128'(O_RDATA), {64'h0, 64'h5});
        check("hold2_ready", 128'(I_READY), 128'(0));
        step();
        WB_WE = '0;
        @(negedge CLK);
        check("hold3_data", 128'(O_RDATA), {64'h0, 64'h9});
        check("hold3_valid", 128'(O_VALID), 128'(1));
        check("hold3_ready", 128'(I_READY), 128'(0));
        step();
        O_READY = 1'b1;
        @(negedge CLK);
        check("release_ready", 128'(I_READY), 128'(1));
        step();
        @(negedge CLK);
        check("release_valid", 128'(O_VALID), 128'(0));

        // Eight back-to-back requests with colliding random write-backs
        pops0 = pops;
        for (int k = 0; k < 8; k++) begin
            step();
            I_VALID  = 1'b1;
            I_RE     = 2'($urandom_range(0, 3));
            I_RADDR  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            WB_WE    = 2'($urandom_range(0, 3));
            WB_WADDR = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            WB_WDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge CLK);
            check("b2b_ready", 128'(I_READY), 128'(1));
            if (k > 0) check("b2b_valid", 128'(O_VALID), 128'(1));
        end
        step();
        idle();
        @(negedge CLK);
        check("b2b_last_valid", 128'(O_VALID), 128'(1));
        step();
        @(negedge CLK);
        check("b2b_drained", 128'(O_VALID), 128'(0));
        check("b2b_count", 128'(pops - pops0), 128'(8));

        // Reset while holding a bypassed operand
        step();
        I_VALID  = 1'b1;
        I_RE     = 2'b01;
        I_RADDR  = {5'd0, 5'd9};
        O_READY  = 1'b0;
        WB_WE    = 2'b01;
        WB_WADDR = {5'd0, 5'd9};
        WB_WDATA = {64'h0, 64'h77};
        step();
        idle();
        @(negedge CLK);
        check("rstmid_hold", 128'(O_RDATA), {64'h0, 64'h77});
        step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        @(negedge CLK);
        check("rstmid_valid", 128'(O_VALID), 128'(0));
        check("rstmid_ready", 128'(I_READY), 128'(1));
        check("rstmid_rf_re", 128'(RF_RE), 128'(0));
        step();
        O_READY  = 1'b1;
        WB_WE    = 2'b10;
        WB_WADDR = {5'd9, 5'd0};
        WB_WDATA = {64'h88, 64'h0};
        step();
        WB_WE   = '0;
        I_VALID = 1'b1;
        I_RE    = 2'b01;
        I_RADDR = {5'd0, 5'd9};
        step();
        idle();
        @(negedge CLK);
        check("post_rst_data", 128'(O_RDATA), {64'h0, 64'h88});

        step();
        step();
        @(negedge CLK);
        check("sb_drain", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_operand_fetch.md
RF_OPERAND_FETCH -- requirements
Module: rf_operand_fetch

Interface
REQ-001 SHALL have parameters: DW, 64, register data width; AW, 5, register address width; NUM_READ, 2, operands per request; NUM_WRITE, 2, write-back ports snooped.
REQ-002 SHALL have ports, in this order:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset; one clock; reset is synchronous and active-low.
- I_VALID  in  1  upstream request valid.
- I_READY  out  1  upstream request accepted.
- I_RE  in  NUM_READ  per-operand read enable.
- I_RADDR  in  NUM_READ*AW  operand addresses, lane i at [i*AW +: AW].
- RF_RE  out  NUM_READ  register-file read enables.
- RF_RADDR  out  NUM_READ*AW  register-file read addresses.
- RF_RDATA  in  NUM_READ*DW  register-file read data; returned one cycle after RF_RE; held while RF_RE is low.
- WB_WE  in  NUM_WRITE  write-back enables (the same writes the register file commits).
- WB_WADDR  in  NUM_WRITE*AW  write-back addresses.
- WB_WDATA  in  NUM_WRITE*DW  write-back data.
- O_VALID  out  1  operands valid.
- O_READY  in  1  downstream accepts operands.
- O_RDATA  out  NUM_READ*DW  operand data.

Function
REQ-003 SHALL assert I_READY = !O_VALID || O_READY (single stage, no bubble on continuous flow).
REQ-004 SHALL define accept = I_VALID && I_READY; RF_RE[i] = accept && I_RE[i]; RF_RADDR = I_RADDR; combinational.
REQ-005 SHALL set O_VALID the cycle after accept; SHALL clear O_VALID after O_VALID && O_READY with no new accept; latency is exactly 1 cycle.
REQ-006 SHALL register per lane, on accept: address, enable mask I_RE[i], hit flag and bypass data.
REQ-007 SHALL set the lane hit flag on accept when any WB_WE[j] writes the address being read in that cycle; bypass data = the matching WB_WDATA. The register file returns pre-write data in that case.
REQ-008 SHALL resolve multiple matching writes in one cycle by highest index j, matching the register file's WAW priority.
REQ-009 SHALL, while O_VALID && !O_READY (hold), update each enabled lane's hit flag and bypass data on any matching write, with the REQ-008 priority. Stale held operands are thereby refreshed.
REQ-010 SHALL drive O_RDATA lane i = 0 if the mask bit is clear; else bypass data if hit is set; else RF_RDATA lane i.
REQ-011 SHALL keep O_RDATA stable during hold except for refreshes under REQ-009.
REQ-012 SHALL clear hit flags on accept before applying REQ-007, so no hit carries over between requests.
REQ-013 SHALL treat address 0 like any other address; no hardwired-zero register.
REQ-014 SHALL accept a request in the same cycle O_READY consumes the current one; the new request's data appears the next cycle.

Reset
REQ-015 SHALL, while RST_N is low at a clock edge, clear O_VALID, all hit flags and all mask bits. Stored addresses and bypass data are don't-care.
REQ-016 SHALL drive RF_RE = 0 and I_READY = 1 one cycle after reset is applied. A request in flight when reset is asserted is discarded with no output.

Structure
REQ-017 SHALL take global macros from ncpu64k_config.vh; no new typedefs are needed.
REQ-018 SHALL instantiate one sub-module per lane, rf_byp_lane, containing the address and write compare, the priority select, and the hit and data registers.
REQ-019 SHALL be 120-400 lines of RTL, with no latches and no asynchronous logic.

Verification
REQ-020 Basic read:
- Stimulus: RF r3=0x11 and r4=0x22; request {r3,r4}; O_READY=1.
- Required response: O_VALID asserted 1 cycle later with {0x11,0x22}; RF_RE=2'b11 in the accept cycle.
REQ-021 Same-cycle bypass:
- Stimulus: request r5 while WB port 0 writes r5=0xAB.
- Required response: O_RDATA=0xAB (not the old r5).
- Stimulus: ports 0 and 1 both write r5 (0x1, 0x2).
- Required response: O_RDATA=0x2.
REQ-022 Hold refresh:
- Stimulus: operand r7=0x5 held with O_READY=0 for 3 cycles; write r7=0x9 in the 2nd hold cycle.
- Required response: O_RDATA changes to 0x9 the next cycle; O_VALID stays high; I_READY=0 throughout the hold.
REQ-023 Masked lane and back-to-back:
- Stimulus: I_RE=2'b01.
- Required response: lane 1 outputs 0; RF_RE[1]=0.
- Stimulus: continuous I_VALID and O_READY for 8 requests.
- Required response: 8 results on consecutive cycles.
REQ-024 Reset mid-operation:
- Stimulus: pull RST_N low while O_VALID=1 during hold.
- Required response: next cycle O_VALID=0, I_READY=1; a later request to the previously bypassed address returns RF data (hit cleared).
